rv32i_seq: RTL

RV32I_SEQ -- requirements
Module: rv32i_seq

---
 rtl/rv32i_pkg.sv | 23 ++
 rtl/rv32i_wdt.sv | 26 ++
 rtl/rv32i_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared types for the rv32i multi-cycle sequencer:
// state codes, fault codes and default memory timeout.
package rv32i_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE   = 2'd0,
    FC_DECODE = 2'd1,
    FC_MEMTO  = 2'd2,
    FC_HALT   = 2'd3
  } fc_t;

  localparam int MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/rv32i_wdt.sv
// Memory-wait watchdog: counts MEM cycles without ack,
// flags the cycle that reaches the timeout.
module rv32i_wdt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic clear,
  input  logic count,
  input  logic freeze,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clear)
      cnt <= '0;
    else if (count && !freeze)
      cnt <= cnt + 1'b1;
  end

  assign expired = count && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/rv32i_seq.sv
// Multi-cycle RV32I control sequencer with stall/freeze,
// memory watchdog, sticky fault reporting and retire count.
module rv32i_seq
  import rv32i_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int RET_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hold,
  input  logic             is_mem,
  input  logic             is_store,
  input  logic             rd_write,
  input  logic             fault_in,
  input  logic             halt_req,
  input  logic             mem_ack,
  output logic             ins_latch,
  output logic             mem_req,
  output logic             drw,
  output logic             bus_oe,
  output logic             rf_we,
  output logic             pc_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [RET_W-1:0] retired
);

  logic [2:0]       st_q, st_d;
  logic             fault_q, fault_d;
  logic [1:0]       fc_q, fc_d;
  logic             store_q, rdw_q;
  logic [RET_W-1:0] ret_q;
  logic             run;
  logic             expired;

  assign run = en && !hold;

  rv32i_wdt #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_wdt (
    .clk     (clk),
    .clear   (rst || (st_q != MEM)),
    .count   ((st_q == MEM) && !mem_ack),
    .freeze  (!run),
    .expired (expired)
  );

  always_comb begin
    st_d    = st_q;
    fault_d = fault_q;
    fc_d    = fc_q;
    if (run) begin
      unique case (1'b1)
        st_q == FETCH:   st_d = DECODE;
        st_q == DECODE:  st_d = EXECUTE;
        st_q == EXECUTE: begin
          if (fault_in) begin
            st_d    = HALT;
            fault_d = 1'b1;
            if (fc_q == FC_NONE) fc_d = FC_DECODE;
          end else if (halt_req) begin
            st_d = HALT;
            if (fc_q == FC_NONE) fc_d = FC_HALT;
          end else if (is_mem) begin
            st_d = MEM;
          end else begin
            st_d = WB;
          end
        end
        st_q == MEM: begin
          // an ack in the timeout cycle still completes
          if (mem_ack) begin
            st_d = WB;
          end else if (expired) begin
            st_d    = HALT;
            fault_d = 1'b1;
            if (fc_q == FC_NONE) fc_d = FC_MEMTO;
          end
        end
        st_q == WB:   st_d = FETCH;
        st_q == HALT: st_d = HALT;
        default: begin
          st_d    = HALT;
          fault_d = 1'b1;
          if (fc_q == FC_NONE) fc_d = FC_DECODE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= FETCH;
      fault_q <= 1'b0;
      fc_q    <= FC_NONE;
      store_q <= 1'b0;
      rdw_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      st_q    <= st_d;
      fault_q <= fault_d;
      fc_q    <= fc_d;
      if (run && st_q == EXECUTE) begin
        store_q <= is_store;
        rdw_q   <= rd_write;
      end
      if (run && st_q == WB)
        ret_q <= ret_q + 1'b1;
    end
  end

  assign ins_latch  = run && (st_q == FETCH);
  assign mem_req    = !hold && (st_q == MEM);
  assign drw        = (st_q == MEM) && store_q;
  assign bus_oe     = !hold && (st_q != HALT);
  assign rf_we      = run && (st_q == WB) && rdw_q && !store_q;
  assign pc_we      = run && (st_q == WB);
  assign state      = st_q;
  assign halted     = (st_q == HALT);
  assign fault      = fault_q;
  assign fault_code = fc_q;
  assign retired    = ret_q;

endmodule
